router_pkt_tx: RTL and testbench

- Packet transmitter that drives the router input port (pkt_valid, data_in, busy).
- Upstream logic preloads payload bytes into an internal buffer, then issues a start command with destination and length.
- The block emits header, payload and parity bytes, honouring router busy backpressure. An optional inverted-parity injection produces error packets.

---
 rtl/router_pkt_pkg.sv | 26 ++
 rtl/router_tx_fifo.sv | 72 +++++++
 rtl/router_pkt_tx.sv | 197 +++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkt_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the router packet transmit path.
package router_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    PARITY  = 3'd3,
    GAP     = 3'd4
  } tx_state_t;

  localparam logic [1:0] ADDR_INVALID = 2'b11;
  localparam int         PKT_MAX_LEN  = 63;
  localparam int         LEN_W        = $clog2(PKT_MAX_LEN + 1);

  function automatic logic [7:0] make_header(input logic [LEN_W-1:0] len, input logic [1:0] addr);
    return {len, addr};
  endfunction

  // Trailer byte: running XOR parity, optionally inverted to force a router parity error.
  function automatic logic [7:0] parity_byte(input logic [7:0] par, input logic inj);
    return par ^ {8{inj}};
  endfunction

endpackage

// File: rtl/router_tx_fifo.sv
`timescale 1ns/1ps
// Synchronous first-word-fall-through byte FIFO; head byte is visible on rd_data while not empty.
module router_tx_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_s;
  logic          full_r;
  logic          empty_r;
  logic          wr_ok_s;
  logic          rd_ok_s;

  // Qualify requests and compute the next occupancy; a write while full is dropped.
  always_comb begin
    wr_ok_s = wr_en & ~full_r;
    rd_ok_s = rd_en & ~empty_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (rd_ok_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_s;
      full_r  <= (count_s == CNT_FULL);
      empty_r <= (count_s == '0);
    end
  end

  // Storage array; reset scrubs stale payload so it can never leak into a later packet.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 8'h00;
    end else if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = full_r;
  assign count   = count_r;

endmodule

// File: rtl/router_pkt_tx.sv
`timescale 1ns/1ps
// Router input-port packet transmitter: header, buffered payload and XOR parity byte,
// stalled by router busy, with optional parity inversion for error packets.
module router_pkt_tx
  import router_pkt_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int MIN_GAP = 2   // must be >= 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   buf_full,
  output logic [$clog2(DEPTH):0] buf_count,
  input  logic                   start,
  input  logic [1:0]             dest_addr,
  input  logic [5:0]             pay_len,
  input  logic                   inj_err,
  output logic                   start_ready,
  input  logic                   busy,
  output logic                   pkt_valid,
  output logic [7:0]             data_out,
  output logic                   tx_active,
  output logic                   done,
  output logic                   addr_err
);

  localparam int               CW       = $clog2(DEPTH) + 1;
  localparam int               GAP_W    = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  tx_state_t        state_r, state_s;
  logic [LEN_W-1:0] len_r, len_s;
  logic [LEN_W-1:0] rem_r, rem_s;
  logic             inj_r, inj_s;
  logic [7:0]       parity_r, parity_s;
  logic [GAP_W-1:0] gap_r, gap_s;
  logic             pkt_valid_r, pkt_valid_s;
  logic [7:0]       data_out_r, data_out_s;
  logic             done_r, done_s;
  logic             addr_err_r, addr_err_s;
  logic             tx_active_r, tx_active_s;
  logic [7:0]       hdr_s;
  logic             start_ready_s;
  logic             rd_en_s;
  logic [7:0]       rd_data_s;
  logic             buf_full_s;
  logic [CW-1:0]    buf_count_s;

  router_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en_s),
    .rd_data (rd_data_s),
    .full    (buf_full_s),
    .count   (buf_count_s)
  );

  // A start is only admitted once the whole payload is already buffered, so pops never underflow.
  assign start_ready_s = (state_r == IDLE) && (buf_count_s >= CW'(pay_len));

  // Next-state and next-output decode; every held value defaults to its register.
  always_comb begin
    hdr_s       = make_header(pay_len, dest_addr);
    state_s     = state_r;
    len_s       = len_r;
    rem_s       = rem_r;
    inj_s       = inj_r;
    parity_s    = parity_r;
    gap_s       = gap_r;
    pkt_valid_s = pkt_valid_r;
    data_out_s  = data_out_r;
    done_s      = 1'b0;
    addr_err_s  = 1'b0;
    rd_en_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && start_ready_s) begin
          if (dest_addr == ADDR_INVALID) begin
            addr_err_s = 1'b1;
          end else begin
            len_s       = pay_len;
            inj_s       = inj_err;
            parity_s    = hdr_s;
            data_out_s  = hdr_s;
            pkt_valid_s = 1'b1;
            state_s     = HEADER;
          end
        end else begin
          addr_err_s = 1'b0;
        end
      end
      HEADER: begin
        if (!busy) begin
          if (len_r != '0) begin
            rd_en_s    = 1'b1;
            data_out_s = rd_data_s;
            parity_s   = parity_r ^ rd_data_s;
            rem_s      = len_r;
            state_s    = PAYLOAD;
          end else begin
            data_out_s  = parity_byte(parity_r, inj_r);
            pkt_valid_s = 1'b0;
            state_s     = PARITY;
          end
        end else begin
          rd_en_s = 1'b0;
        end
      end
      PAYLOAD: begin
        if (!busy) begin
          rem_s = rem_r - LEN_ONE;
          if (rem_r > LEN_ONE) begin
            rd_en_s    = 1'b1;
            data_out_s = rd_data_s;
            parity_s   = parity_r ^ rd_data_s;
          end else begin
            data_out_s  = parity_byte(parity_r, inj_r);
            pkt_valid_s = 1'b0;
            state_s     = PARITY;
          end
        end else begin
          rd_en_s = 1'b0;
        end
      end
      PARITY: begin
        if (!busy) begin
          data_out_s = 8'h00;
          done_s     = 1'b1;
          gap_s      = '0;
          state_s    = GAP;
        end else begin
          done_s = 1'b0;
        end
      end
      GAP: begin
        if (gap_r == GAP_LAST) begin
          state_s = IDLE;
        end else begin
          gap_s = gap_r + GAP_ONE;
        end
      end
      default: begin
        state_s     = IDLE;
        pkt_valid_s = 1'b0;
        data_out_s  = 8'h00;
      end
    endcase
    tx_active_s = (state_s == HEADER) || (state_s == PAYLOAD) || (state_s == PARITY);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      len_r       <= '0;
      rem_r       <= '0;
      inj_r       <= 1'b0;
      parity_r    <= 8'h00;
      gap_r       <= '0;
      pkt_valid_r <= 1'b0;
      data_out_r  <= 8'h00;
      done_r      <= 1'b0;
      addr_err_r  <= 1'b0;
      tx_active_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      len_r       <= len_s;
      rem_r       <= rem_s;
      inj_r       <= inj_s;
      parity_r    <= parity_s;
      gap_r       <= gap_s;
      pkt_valid_r <= pkt_valid_s;
      data_out_r  <= data_out_s;
      done_r      <= done_s;
      addr_err_r  <= addr_err_s;
      tx_active_r <= tx_active_s;
    end
  end

  assign start_ready = start_ready_s;
  assign buf_full    = buf_full_s;
  assign buf_count   = buf_count_s;
  assign pkt_valid   = pkt_valid_r;
  assign data_out    = data_out_r;
  assign tx_active   = tx_active_r;
  assign done        = done_r;
  assign addr_err    = addr_err_r;

endmodule

// File: tb/tb_router_pkt_tx.sv
`timescale 1ns/1ps
// Scoreboard bench for router_pkt_tx: directed packets push expected bytes, a negedge monitor consumes them.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       buf_full;
  logic [6:0] buf_count;
  logic       start = 1'b0;
  logic [1:0] dest_addr = 2'd0;
  logic [5:0] pay_len = 6'd0;
  logic       inj_err = 1'b0;
  logic       start_ready;
  logic       busy = 1'b0;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_active;
  logic       done;
  logic       addr_err;

  typedef struct packed {
    logic       last;
    logic       pv;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic done_pending = 1'b0;

  router_pkt_tx #(.DEPTH(64), .MIN_GAP(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .buf_full    (buf_full),
    .buf_count   (buf_count),
    .start       (start),
    .dest_addr   (dest_addr),
    .pay_len     (pay_len),
    .inj_err     (inj_err),
    .start_ready (start_ready),
    .busy        (busy),
    .pkt_valid   (pkt_valid),
    .data_out    (data_out),
    .tx_active   (tx_active),
    .done        (done),
    .addr_err    (addr_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic pv, input logic [7:0] d, input logic last);
    exp_t e;
    e.last = last;
    e.pv   = pv;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] a, input logic [5:0] l, input logic inj);
    int n = 0;
    dest_addr = a;
    pay_len   = l;
    inj_err   = inj;
    #1;
    while (start_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("start_ready_wait", start_ready, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check(name, done, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Monitor: every byte the router consumes is matched against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        done_pending = 1'b0;
      end else begin
        if (done_pending || done) check("done_pulse", done, done_pending);
        done_pending = 1'b0;
        if (tx_active && !busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", {pkt_valid, data_out});
          end else begin
            e = exp_q.pop_front();
            check("byte_out", {pkt_valid, data_out}, {e.pv, e.data});
            done_pending = e.last;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] par;

    // Reset values
    tick();
    tick();
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_done", done, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_tx_active", tx_active, 0);
    check("rst_buf_count", buf_count, 0);
    check("rst_buf_full", buf_full, 0);
    check("rst_start_ready", start_ready, 1);
    reset = 1'b0;
    tick();

    // Good packet, no stall
    write_byte(8'hA5);
    write_byte(8'h3C);
    check("good_count_pre", buf_count, 2);
    push(1'b1, 8'h09, 1'b0);
    push(1'b1, 8'hA5, 1'b0);
    push(1'b1, 8'h3C, 1'b0);
    push(1'b0, 8'h90, 1'b1);
    do_start(2'd1, 6'd2, 1'b0);
    wait_done("good_done");
    check("good_count_post", buf_count, 0);

    // Error injection
    write_byte(8'hA5);
    write_byte(8'h3C);
    push(1'b1, 8'h09, 1'b0);
    push(1'b1, 8'hA5, 1'b0);
    push(1'b1, 8'h3C, 1'b0);
    push(1'b0, 8'h6F, 1'b1);
    do_start(2'd1, 6'd2, 1'b1);
    wait_done("inj_done");

    // Zero length, then gap holds start_ready low
    push(1'b1, 8'h02, 1'b0);
    push(1'b0, 8'h02, 1'b1);
    do_start(2'd2, 6'd0, 1'b0);
    wait_done("zero_done");
    check("gap_ready_0", start_ready, 0);
    @(negedge clock);
    check("gap_ready_1", start_ready, 0);
    begin
      int n = 0;
      while (start_ready !== 1'b1 && n < 20) begin
        @(negedge clock);
        n++;
      end
    end
    check("gap_ready_back", start_ready, 1);

    // Busy stall while first payload byte is presented
    write_byte(8'hA5);
    write_byte(8'h11);
    write_byte(8'h22);
    push(1'b1, 8'h0D, 1'b0);
    push(1'b1, 8'hA5, 1'b0);
    push(1'b1, 8'h11, 1'b0);
    push(1'b1, 8'h22, 1'b0);
    push(1'b0, 8'h9B, 1'b1);
    do_start(2'd1, 6'd3, 1'b0);
    tick();
    busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("stall_data", data_out, 8'hA5);
      check("stall_pv", pkt_valid, 1);
      check("stall_count", buf_count, 2);
      @(posedge clock);
      #1;
    end
    busy = 1'b0;
    wait_done("stall_done");

    // Invalid destination
    do_start(2'd3, 6'd0, 1'b0);
    check("bad_addr_err", addr_err, 1);
    check("bad_addr_pv", pkt_valid, 0);
    check("bad_addr_active", tx_active, 0);
    tick();
    check("bad_addr_pulse_end", addr_err, 0);
    check("bad_addr_count", buf_count, 0);

    // Start with too little buffered data is ignored
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    write_byte(8'h04);
    dest_addr = 2'd3;
    pay_len   = 6'd5;
    start     = 1'b1;
    #1;
    check("short_ready", start_ready, 0);
    tick();
    tick();
    check("short_active", tx_active, 0);
    check("short_addr_err", addr_err, 0);
    check("short_count", buf_count, 4);
    start   = 1'b0;
    pay_len = 6'd4;
    #1;
    check("exact_ready", start_ready, 1);

    // Reset during payload
    push(1'b1, 8'h10, 1'b0);
    do_start(2'd0, 6'd4, 1'b0);
    tick();
    reset = 1'b1;
    busy  = 1'b1;
    tick();
    check("mid_rst_pv", pkt_valid, 0);
    check("mid_rst_data", data_out, 8'h00);
    check("mid_rst_active", tx_active, 0);
    check("mid_rst_count", buf_count, 0);
    reset = 1'b0;
    busy  = 1'b0;
    check("mid_rst_queue", exp_q.size(), 0);
    exp_q.delete();
    tick();

    // Fill to full, drop the 65th write, then send a max-length packet
    for (int i = 0; i < 64; i++) begin
      write_byte(8'(i));
      if (i == 62) check("fill_not_full", buf_full, 0);
    end
    check("fill_full", buf_full, 1);
    check("fill_count", buf_count, 64);
    write_byte(8'hEE);
    check("drop_full", buf_full, 1);
    check("drop_count", buf_count, 64);
    par = 8'hFD;
    push(1'b1, 8'hFD, 1'b0);
    for (int i = 0; i < 63; i++) begin
      push(1'b1, 8'(i), 1'b0);
      par = par ^ 8'(i);
    end
    push(1'b0, par, 1'b1);
    do_start(2'd1, 6'd63, 1'b0);
    wait_done("max_done");
    check("max_count", buf_count, 1);
    push(1'b1, 8'h06, 1'b0);
    push(1'b1, 8'h3F, 1'b0);
    push(1'b0, 8'h39, 1'b1);
    do_start(2'd2, 6'd1, 1'b0);
    wait_done("last_done");
    check("last_count", buf_count, 0);
    check("last_full", buf_full, 0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
